// File: rtl/warp_fetch_scheduler_pkg.sv
// Shared sizing constants and payload typedefs for the warp fetch scheduler.
package warp_fetch_scheduler_pkg;

  localparam int NUM_WARPS   = 4;
  localparam int NUM_THREADS = 4;
  localparam int XLEN        = 32;
  localparam int UUID_WIDTH  = 44;
  localparam int NW_WIDTH    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

  localparam logic [XLEN-1:0] STARTUP_PC = 32'h8000_0000;

  // Contents of the output register presented to the fetch unit.
  typedef struct packed {
    logic [UUID_WIDTH-1:0]  uuid;
    logic [NW_WIDTH-1:0]    wid;
    logic [NUM_THREADS-1:0] tmask;
    logic [XLEN-1:0]        pc;
  } sched_payload_t;

  // Next-PC return from decode/execute.
  typedef struct packed {
    logic [NW_WIDTH-1:0]    wid;
    logic [XLEN-1:0]        pc;
    logic [NUM_THREADS-1:0] tmask;
    logic                   halt;
  } unlock_payload_t;

endpackage

// File: rtl/warp_fetch_scheduler_if.sv
// Spawn, unlock and schedule-handshake signals of the warp fetch scheduler.
// master = scheduler side, slave = warp control / fetch unit side.
interface warp_fetch_scheduler_if;
  import warp_fetch_scheduler_pkg::*;

  logic                   wspawn_valid;
  logic [NUM_WARPS-1:0]   wspawn_mask;
  logic [XLEN-1:0]        wspawn_pc;

  logic                   unlock_valid;
  logic [NW_WIDTH-1:0]    unlock_wid;
  logic [XLEN-1:0]        unlock_pc;
  logic [NUM_THREADS-1:0] unlock_tmask;
  logic                   unlock_halt;

  logic                   sched_valid;
  logic                   sched_ready;
  logic [NW_WIDTH-1:0]    sched_wid;
  logic [XLEN-1:0]        sched_pc;
  logic [NUM_THREADS-1:0] sched_tmask;
  logic [UUID_WIDTH-1:0]  sched_uuid;

  modport master (
    input  wspawn_valid, wspawn_mask, wspawn_pc,
    input  unlock_valid, unlock_wid, unlock_pc, unlock_tmask, unlock_halt,
    input  sched_ready,
    output sched_valid, sched_wid, sched_pc, sched_tmask, sched_uuid
  );

  modport slave (
    output wspawn_valid, wspawn_mask, wspawn_pc,
    output unlock_valid, unlock_wid, unlock_pc, unlock_tmask, unlock_halt,
    output sched_ready,
    input  sched_valid, sched_wid, sched_pc, sched_tmask, sched_uuid
  );

endinterface

// File: rtl/warp_fetch_scheduler_arbiter.sv
// Combinational round-robin arbiter: the first requester found searching
// upward from last+1 (wrapping) wins. N must be a power of two.
module warp_rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 valid
);
  localparam int W = $clog2(N);

  logic [W-1:0] cand;

  // Scan candidates in priority order; the W-bit add wraps modulo N.
  always_comb begin
    grant_idx = '0;
    valid     = 1'b0;
    cand      = '0;
    for (int i = 1; i <= N; i++) begin
      cand = last + W'(i);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        grant_idx = cand;
      end
    end
    grant = valid ? (N'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/warp_fetch_scheduler.sv
// Per-warp fetch sequencer: tracks PC / thread mask / active / stalled per
// warp and issues one fetch request per cycle, round-robin over eligible warps.
// A warp is stalled as soon as it is loaded into the output register and stays
// so until decode/execute returns an unlock, so at most one fetch per warp is
// in flight. Optional macro WSCHED_PERF_EN adds idle/stall perf counters.
module warp_fetch_scheduler
  import warp_fetch_scheduler_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  warp_fetch_scheduler_if.master bus,
  output logic                 busy,
  output logic [63:0]          perf_idle_cycles,
  output logic [63:0]          perf_stall_cycles
);

  logic [NUM_WARPS-1:0]   active_q;
  logic [NUM_WARPS-1:0]   stalled_q;
  logic [XLEN-1:0]        pc_q    [NUM_WARPS];
  logic [NUM_THREADS-1:0] tmask_q [NUM_WARPS];
  logic [NW_WIDTH-1:0]    last_grant_q;
  logic [UUID_WIDTH-1:0]  uuid_ctr_q;
  logic                   or_valid_q;
  sched_payload_t         or_q;

  logic [NUM_WARPS-1:0]   eligible;
  logic [NUM_WARPS-1:0]   rr_grant;
  logic [NW_WIDTH-1:0]    rr_idx;
  logic                   rr_valid;
  logic                   load;
  logic                   fire;
  logic                   unlock_ok;
  unlock_payload_t        ul;

  assign ul        = '{wid: bus.unlock_wid, pc: bus.unlock_pc,
                       tmask: bus.unlock_tmask, halt: bus.unlock_halt};
  assign eligible  = active_q & ~stalled_q;
  assign fire      = or_valid_q && bus.sched_ready;
  assign load      = (!or_valid_q || bus.sched_ready) && rr_valid;
  assign unlock_ok = bus.unlock_valid && stalled_q[ul.wid];
  assign busy      = |active_q;

  warp_rr_arbiter #(.N(NUM_WARPS)) u_arb (
    .req       (eligible),
    .last      (last_grant_q),
    .grant     (rr_grant),
    .grant_idx (rr_idx),
    .valid     (rr_valid)
  );

  // Output register and warp table: load/stall the winner, apply unlock and spawn.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q     <= NUM_WARPS'(1);
      stalled_q    <= '0;
      last_grant_q <= NW_WIDTH'(NUM_WARPS - 1);
      uuid_ctr_q   <= '0;
      or_valid_q   <= 1'b0;
      or_q         <= '0;
      for (int i = 0; i < NUM_WARPS; i++) begin
        pc_q[i]    <= (i == 0) ? STARTUP_PC : '0;
        tmask_q[i] <= (i == 0) ? NUM_THREADS'(1) : '0;
      end
    end else begin
      if (load) begin
        or_valid_q   <= 1'b1;
        or_q         <= '{uuid: uuid_ctr_q, wid: rr_idx,
                          tmask: tmask_q[rr_idx], pc: pc_q[rr_idx]};
        uuid_ctr_q   <= uuid_ctr_q + 1'b1;
        last_grant_q <= rr_idx;
      end else if (fire) begin
        or_valid_q   <= 1'b0;
      end
      // Winner, unlock target and spawn targets are always distinct warps.
      for (int i = 0; i < NUM_WARPS; i++) begin
        if (load && rr_grant[i]) stalled_q[i] <= 1'b1;
        if (unlock_ok && ul.wid == NW_WIDTH'(i)) begin
          stalled_q[i] <= 1'b0;
          if (ul.halt) begin
            active_q[i] <= 1'b0;
          end else begin
            pc_q[i]    <= ul.pc;
            tmask_q[i] <= ul.tmask;
          end
        end
        if (bus.wspawn_valid && bus.wspawn_mask[i] && !active_q[i]) begin
          active_q[i]  <= 1'b1;
          stalled_q[i] <= 1'b0;
          pc_q[i]      <= bus.wspawn_pc;
          tmask_q[i]   <= NUM_THREADS'(1);
        end
      end
    end
  end

  assign bus.sched_valid = or_valid_q;
  assign bus.sched_wid   = or_q.wid;
  assign bus.sched_pc    = or_q.pc;
  assign bus.sched_tmask = or_q.tmask;
  assign bus.sched_uuid  = or_q.uuid;

  // Flag unlocks aimed at a warp that has no fetch outstanding (they are dropped).
  always @(posedge clk) begin
    if (!reset && bus.unlock_valid)
      assert (stalled_q[bus.unlock_wid])
        else $warning("unlock to non-stalled warp %0d ignored", bus.unlock_wid);
  end

`ifdef WSCHED_PERF_EN
  logic [63:0] idle_q;
  logic [63:0] stall_q;

  // Saturating counters for empty-while-busy and backpressured cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_q  <= '0;
      stall_q <= '0;
    end else begin
      if (!or_valid_q && busy && idle_q != '1)
        idle_q <= idle_q + 64'd1;
      if (or_valid_q && !bus.sched_ready && stall_q != '1)
        stall_q <= stall_q + 64'd1;
    end
  end

  assign perf_idle_cycles  = idle_q;
  assign perf_stall_cycles = stall_q;
`else
  assign perf_idle_cycles  = '0;
  assign perf_stall_cycles = '0;
`endif

endmodule

// File: doc/warp_fetch_scheduler.md
# warp_fetch_scheduler

Per-warp fetch sequencer in front of the instruction-fetch stage: holds each warp's PC, thread mask and active/stalled state, and issues one fetch request per cycle to the fetch unit's schedule handshake. Picks among eligible warps round-robin. Stalls a warp from issue until decode/execute returns an unlock with its next PC. This guarantees at most one in-flight fetch per warp. Sits between warp-control logic (spawn, branch, halt) and the fetch/icache request path.

## Interface
- NUM_WARPS, 4: warp count, power of two, ≥2
- NUM_THREADS, 4: threads per warp
- XLEN, 32: PC width
- UUID_WIDTH, 44: instruction tag width
- STARTUP_PC, 32'h80000000: warp-0 PC after reset
- NW_WIDTH, log2(NUM_WARPS): derived warp-id width
- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high
- wspawn_valid  in  1  spawn request
- wspawn_mask  in  NUM_WARPS  warps to activate
- wspawn_pc  in  XLEN  start PC for spawned warps
- unlock_valid  in  1  next-PC return for a stalled warp
- unlock_wid  in  NW_WIDTH  warp being unlocked
- unlock_pc  in  XLEN  next PC (PC+4 or branch target)
- unlock_tmask  in  NUM_THREADS  new thread mask
- unlock_halt  in  1  warp terminates instead of resuming
- sched_valid  out  1  fetch request valid
- sched_ready  in  1  fetch unit accepts
- sched_wid  out  NW_WIDTH  warp id
- sched_pc  out  XLEN  fetch PC
- sched_tmask  out  NUM_THREADS  thread mask
- sched_uuid  out  UUID_WIDTH  instruction uid
- busy  out  1  any warp active
- perf_idle_cycles  out  64  perf counter (see Configuration)
- perf_stall_cycles  out  64  perf counter (see Configuration)

## Operation
- Per-warp state: active, stalled, pc, tmask.
- eligible = active & ~stalled.
- Output register (OR) loads when `!sched_valid || sched_ready` and eligible ≠ 0.
  - Winner: round-robin, searching from (last_grant+1) mod NUM_WARPS upward.
  - OR takes the winner's wid/pc/tmask and uuid = uuid_ctr. uuid_ctr increments and wraps modulo 2^UUID_WIDTH.
  - stalled[winner] is set on the same edge as the load, not on fire, so the warp cannot be picked again while it sits in the OR.
- OR empties (sched_valid→0) on fire when nothing eligible remains.
- Unlock, applied only when unlock_valid and stalled[unlock_wid]:
  - unlock_halt=0: stalled←0, pc←unlock_pc, tmask←unlock_tmask.
  - unlock_halt=1: active←0, stalled←0.
  - Unlock to a non-stalled warp is ignored; simulation assertion fires.
- Spawn: each warp i with wspawn_mask[i] & ~active[i] gets active←1, stalled←0, pc←wspawn_pc, tmask←1 (thread 0). Already-active warps are untouched.
- Same-cycle spawn and unlock are both applied; they cannot target the same warp, since spawn needs the warp inactive and unlock needs it stalled.
- A tmask of all zeros on a non-halt unlock is legal and is passed through unchanged.
- busy = |active. busy does not include OR contents; a halted warp's last request may still be in flight.

## Timing
- Reset values: warp 0 active, pc=STARTUP_PC, tmask=1. Other warps inactive. All stalled=0, last_grant=NUM_WARPS-1, uuid_ctr=0, sched_valid=0, sched_* data=0, busy=1, perf counters=0.
- First request: sched_valid=1 after the first edge following reset release, with wid 0 and uuid 0.
- Unlock sampled at edge k → warp eligible after k → request can appear after edge k+1, i.e. 1-cycle turnaround.
- Back-to-back: with ≥2 eligible warps and sched_ready=1, one fire per cycle.
- Backpressure: while sched_valid && !sched_ready, all sched_* outputs hold stable. New eligibility is not reflected until the fire.
- Reset mid-operation discards the OR and all warp state; in-flight unlocks are lost.

## Configuration
- WSCHED_PERF_EN defined:
  - perf_idle_cycles increments each cycle with sched_valid=0 and busy=1.
  - perf_stall_cycles increments each cycle with sched_valid && !sched_ready.
  - Both saturate at 2^64-1.
- Undefined: both outputs tied to 0 and no counter flops are synthesized.

## Structure
- Shared package holds:
  - NW_WIDTH and UUID_WIDTH derivation.
  - A packed typedef for the schedule payload {uuid, wid, tmask, pc}.
  - A packed typedef for the unlock payload {wid, pc, tmask, halt}.
- One sub-module: warp_rr_arbiter.
  - Parameterized N, purely combinational.
  - Inputs: request mask, last-grant pointer.
  - Outputs: one-hot grant, grant index, valid.

## Test plan
- Reset release with sched_ready=1 → one request wid=0, pc=0x80000000, tmask=0001, uuid=0. No further request until unlock.
- Unlock wid0 pc=0x80000004 at cycle k → request wid0 pc=0x80000004 uuid=1 visible after edge k+1.
- Spawn mask=1111 pc=0x1000, warp 0 stalled → warps 1,2,3 issued in order 1,2,3 on consecutive cycles with uuids incrementing. Warp 0 is unaffected.
- sched_ready=0 for 5 cycles with 3 eligible warps → payload held constant. After release, remaining warps follow in round-robin order. perf_stall_cycles=5 with WSCHED_PERF_EN.
- Unlock with halt for all active warps → busy falls to 0 and sched_valid stays 0. Unlock to an unstalled warp → no state change, assertion fires.
- Reset asserted while request pending and sched_ready=0 → next cycle sched_valid=0, then the reset sequence of the first scenario repeats.
